pipeline_exec_controller: RTL and testbench



---
 rtl/pipeline_exec_controller.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_exec_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_controller.sv
// -----------------------------------------------------------------------------
// pipeline_exec_controller
//
// Run/step sequencer for the five-stage pipeline (IF, ID, EX, MA, WB).
// Drives the shared stage clock enable from debug commands (RUN, STEP, STOP,
// CLEAR). It also lets a HALT seen in ID drain through EX/MA/WB before parking
// in DONE, and it counts enabled cycles for the debug unit.
//
// Parameters:
//   NB_CYCLES     width of the enabled-cycle counter (the counter saturates)
//   DRAIN_CYCLES  enabled cycles still issued after HALT is seen (1..15)
//   NB_DRAIN      width of the drain counter, 2**NB_DRAIN > DRAIN_CYCLES
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_cmd_valid      command strobe, sampled every cycle
//   i_cmd[1:0]       00 RUN, 01 STEP, 10 STOP, 11 CLEAR
//   i_halt_detected  ID decodes HALT (only meaningful while o_clk_en=1)
//   o_clk_en         clock enable to all pipeline stage registers
//   o_pipe_reset     one-cycle pipeline reset pulse following a CLEAR
//   o_busy           state is RUN or STEP
//   o_done           state is DONE (halted and drained)
//   o_halt_seen      HALT captured; drain in progress or complete
//   o_cycle_count    enabled cycles since reset or CLEAR
//   o_state[1:0]     IDLE=0, RUN=1, STEP=2, DONE=3
// -----------------------------------------------------------------------------
module pipeline_exec_controller #(
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int NB_DRAIN     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  input  logic                 i_halt_detected,
  output logic                 o_clk_en,
  output logic                 o_pipe_reset,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_halt_seen,
  output logic [NB_CYCLES-1:0] o_cycle_count,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [NB_DRAIN-1:0]  DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);
  localparam logic [NB_DRAIN-1:0]  DRAIN_ONE  = NB_DRAIN'(1);
  localparam logic [NB_CYCLES-1:0] COUNT_MAX  = {NB_CYCLES{1'b1}};
  localparam logic [NB_CYCLES-1:0] COUNT_ONE  = NB_CYCLES'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               state_reg,       state_next;
  logic                 halt_seen_reg,   halt_seen_next;
  logic [NB_DRAIN-1:0]  drain_reg,       drain_next;
  logic [NB_CYCLES-1:0] cycle_count_reg, cycle_count_next;
  logic                 pipe_reset_reg,  pipe_reset_next;

  // ---------------------------------------------------------------------------
  // Command and event decode
  // ---------------------------------------------------------------------------
  logic clk_en;
  logic cmd_run;
  logic cmd_step;
  logic cmd_stop;
  logic cmd_clear;
  logic halt_capture;
  logic drain_step;
  logic drain_finish;

  assign clk_en    = (state_reg == ST_RUN) || (state_reg == ST_STEP);

  assign cmd_run   = i_cmd_valid && (i_cmd == CMD_RUN);
  assign cmd_step  = i_cmd_valid && (i_cmd == CMD_STEP);
  assign cmd_stop  = i_cmd_valid && (i_cmd == CMD_STOP);
  assign cmd_clear = i_cmd_valid && (i_cmd == CMD_CLEAR);

  // HALT is only trusted in an enabled cycle and only the first one counts;
  // later HALT reports belong to instructions that are already being drained.
  assign halt_capture = clk_en && i_halt_detected && !halt_seen_reg;

  // Every enabled cycle after the capture retires one drain slot. The nonzero
  // guard keeps the counter from wrapping should the block ever be enabled
  // with an exhausted drain.
  assign drain_step   = clk_en && halt_seen_reg && (drain_reg != '0);
  assign drain_finish = drain_step && (drain_reg == DRAIN_ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. CLEAR beats everything, then drain completion
  // (which must win over a simultaneous STOP), then the per-state commands.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (cmd_clear) begin
      state_next = ST_IDLE;
    end else if (drain_finish) begin
      state_next = ST_DONE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_run) begin
            state_next = ST_RUN;
          end else if (cmd_step) begin
            state_next = ST_STEP;
          end
        end
        ST_RUN: begin
          // Pause keeps the halt/drain bookkeeping so a resumed RUN or STEP
          // continues the drain where it left off.
          if (cmd_stop) begin
            state_next = ST_IDLE;
          end
        end
        ST_STEP: begin
          // A step is one enabled cycle; commands other than CLEAR are dropped.
          state_next = ST_IDLE;
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Halt/drain, cycle counter and pipeline-reset pulse: next values
  // ---------------------------------------------------------------------------
  always_comb begin
    halt_seen_next   = halt_seen_reg;
    drain_next       = drain_reg;
    cycle_count_next = cycle_count_reg;
    pipe_reset_next  = 1'b0;

    if (cmd_clear) begin
      halt_seen_next   = 1'b0;
      drain_next       = '0;
      cycle_count_next = '0;
      pipe_reset_next  = 1'b1;
    end else begin
      if (halt_capture) begin
        halt_seen_next = 1'b1;
        drain_next     = DRAIN_LOAD;
      end else if (drain_step) begin
        drain_next = drain_reg - DRAIN_ONE;
      end

      if (clk_en && (cycle_count_reg != COUNT_MAX)) begin
        cycle_count_next = cycle_count_reg + COUNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halt_seen_reg   <= 1'b0;
      drain_reg       <= '0;
      cycle_count_reg <= '0;
      pipe_reset_reg  <= 1'b0;
    end else begin
      halt_seen_reg   <= halt_seen_next;
      drain_reg       <= drain_next;
      cycle_count_reg <= cycle_count_next;
      pipe_reset_reg  <= pipe_reset_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state)
  // ---------------------------------------------------------------------------
  assign o_clk_en      = clk_en;
  assign o_busy        = clk_en;
  assign o_done        = (state_reg == ST_DONE);
  assign o_halt_seen   = halt_seen_reg;
  assign o_pipe_reset  = pipe_reset_reg;
  assign o_cycle_count = cycle_count_reg;
  assign o_state       = state_reg;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_exec_controller
//
// Drives two instances with identical stimulus: the default configuration and
// a 4-bit cycle counter copy used to observe saturation. A behavioural model
// tracks mode, halt/drain progress and the true enabled-cycle total; the
// narrow counter is expected to read min(total, 15).
// -----------------------------------------------------------------------------
module tb_pipeline_exec_controller;

  localparam int DRAIN = 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        halt_det;

  logic        clk_en,   clk_en_s;
  logic        pipe_rst, pipe_rst_s;
  logic        busy,     busy_s;
  logic        done,     done_s;
  logic        halt_seen, halt_seen_s;
  logic [31:0] cyc_cnt;
  logic [3:0]  cyc_cnt_s;
  logic [1:0]  state,    state_s;

  pipeline_exec_controller #(
    .NB_CYCLES   (32),
    .DRAIN_CYCLES(DRAIN),
    .NB_DRAIN    (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .i_halt_detected(halt_det),
    .o_clk_en       (clk_en),
    .o_pipe_reset   (pipe_rst),
    .o_busy         (busy),
    .o_done         (done),
    .o_halt_seen    (halt_seen),
    .o_cycle_count  (cyc_cnt),
    .o_state        (state)
  );

  pipeline_exec_controller #(
    .NB_CYCLES   (4),
    .DRAIN_CYCLES(DRAIN),
    .NB_DRAIN    (4)
  ) dut_sat (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .i_halt_detected(halt_det),
    .o_clk_en       (clk_en_s),
    .o_pipe_reset   (pipe_rst_s),
    .o_busy         (busy_s),
    .o_done         (done_s),
    .o_halt_seen    (halt_seen_s),
    .o_cycle_count  (cyc_cnt_s),
    .o_state        (state_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  // Reference model: mode code as published on o_state, halt flag, enabled
  // cycles still owed to the drain, true enabled-cycle total, pending pulse.
  int     m_mode  = 0;
  bit     m_halt  = 1'b0;
  int     m_left  = 0;
  longint m_total = 0;
  bit     m_pr    = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d want %0d", tag, n_cycle, obs, exp);
    end
  endtask

  function automatic longint min15(input longint x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_update(input bit v, input logic [1:0] c, input bit hd, input bit r);
    bit enabled;
    bit drained;
    if (r) begin
      m_mode = 0; m_halt = 0; m_left = 0; m_total = 0; m_pr = 0;
    end else if (v && c == 2'd3) begin
      m_mode = 0; m_halt = 0; m_left = 0; m_total = 0; m_pr = 1;
    end else begin
      enabled = (m_mode == 1) || (m_mode == 2);
      drained = 1'b0;
      m_pr    = 1'b0;
      if (enabled) begin
        m_total++;
        if (m_halt) begin
          m_left--;
          drained = (m_left == 0);
        end else if (hd) begin
          m_halt = 1'b1;
          m_left = DRAIN;
        end
      end
      if (drained) begin
        m_mode = 3;
      end else if (m_mode == 0) begin
        if (v && c == 2'd0)      m_mode = 1;
        else if (v && c == 2'd1) m_mode = 2;
      end else if (m_mode == 1) begin
        if (v && c == 2'd2) m_mode = 0;
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
    end
  endtask

  // One transaction per clock: check the current cycle's outputs against the
  // model, apply this cycle's inputs, then advance the model past the edge.
  task automatic tick(input bit v, input logic [1:0] c, input bit hd, input bit r);
    bit exp_en;
    @(posedge clk);
    #1;
    n_cycle++;
    exp_en = (m_mode == 1) || (m_mode == 2);
    check_val("state",       longint'(state),      longint'(m_mode));
    check_val("clk_en",      longint'(clk_en),     longint'(exp_en));
    check_val("busy",        longint'(busy),       longint'(exp_en));
    check_val("done",        longint'(done),       longint'(m_mode == 3));
    check_val("halt_seen",   longint'(halt_seen),  longint'(m_halt));
    check_val("pipe_reset",  longint'(pipe_rst),   longint'(m_pr));
    check_val("cycle_count", longint'(cyc_cnt),    m_total);
    check_val("sat_count",   longint'(cyc_cnt_s),  min15(m_total));
    check_val("sat_state",   longint'(state_s),    longint'(m_mode));
    $display("cyc %0d v=%0b cmd=%0d hd=%0b rst=%0b | state=%0d en=%0b prst=%0b halt=%0b cnt=%0d sat=%0d",
             n_cycle, v, c, hd, r, state, clk_en, pipe_rst, halt_seen, cyc_cnt, cyc_cnt_s);
    rst       = r;
    cmd_valid = v;
    cmd       = c;
    halt_det  = hd;
    model_update(v, c, hd, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'd0;
    halt_det  = 1'b0;
    model_update(1'b0, 2'd0, 1'b0, 1'b1);

    // Reset, then quiet idle.
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    idle(6);
    check_val("reset_count", longint'(cyc_cnt), 0);

    // Three spaced single steps.
    for (int s = 0; s < 3; s++) begin
      tick(1'b1, 2'd1, 1'b0, 1'b0);
      idle(3);
    end
    check_val("step_count", longint'(cyc_cnt), 3);
    check_val("step_state", longint'(state), 0);

    // RUN with HALT on the 10th enabled cycle.
    tick(1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(9);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    idle(5);
    check_val("halt_state", longint'(state), 3);
    check_val("halt_count", longint'(cyc_cnt), 13);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 2'd1, 1'b0, 1'b0);
    idle(3);

    // CLEAR from DONE.
    tick(1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    check_val("clear_pulse", longint'(pipe_rst), 1);
    idle(1);
    check_val("clear_count", longint'(cyc_cnt), 0);
    check_val("clear_halt",  longint'(halt_seen), 0);

    // RUN 5, pause 4, RUN 5.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 2'd2, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 2'd2, 1'b0, 1'b0);
    idle(1);
    check_val("pause_count", longint'(cyc_cnt), 10);

    // Same with HALT just before STOP: drain finishes after resuming.
    tick(1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b1, 2'd2, 1'b0, 1'b0);
    idle(4);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(3);
    check_val("resume_state", longint'(state), 3);
    check_val("resume_count", longint'(cyc_cnt), 7);

    // CLEAR in the cycle the drain completes.
    tick(1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    idle(2);
    tick(1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
    check_val("clr_drain_state", longint'(state), 0);
    check_val("clr_drain_done",  longint'(done), 0);

    // Saturation of the 4-bit counter.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(21);
    check_val("sat_15", longint'(cyc_cnt_s), 15);
    tick(1'b1, 2'd2, 1'b0, 1'b0);

    // Mid-run reset: no pipe reset pulse afterwards.
    tick(1'b1, 2'd0, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit         v;
      logic [1:0] c;
      bit         hd;
      bit         r;
      v  = ($urandom_range(0, 5) == 0);
      c  = 2'($urandom_range(0, 3));
      if (c == 2'd3 && $urandom_range(0, 2) != 0) c = 2'd0;
      hd = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 249) == 0);
      tick(v, c, hd, r);
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
